// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio shared definitions: MMIO base, register offsets, STATUS bits.
// Optional MMIO_CYCCNT_EN adds the CYCCNT counter register.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [3:0] OFS_GPIO   = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_CYCCNT = 4'hC;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;

  function automatic logic isMmio(
    input logic [31:0] addr
  );
    return (addr & MMIO_BASE) != 32'h0;
  endfunction

  function automatic logic [3:0] regOfs(
    input logic [31:0] addr
  );
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core-side data bus and TX drain port of dmem_mmio.
// Field names follow the core's Memory-stage signal names.
interface dmem_mmio_if;

  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] gpio_out;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (
    output we, a, wd, tx_ready,
    input  rd, gpio_out, tx_valid, tx_data
  );

  modport slave (
    input  we, a, wd, tx_ready,
    output rd, gpio_out, tx_valid, tx_data
  );

endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// Circular transmit FIFO with occupancy count and sticky overflow.
// A push is accepted when full only if a pop frees the slot on that edge.
module tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count,
  input  logic             ovfClr,
  output logic             overflow
);

  logic [WIDTH-1:0] q [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             doPop;
  logic             doPush;
  logic             drop;

  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign rdata  = q[head];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign drop   = push && full && !doPop;

  always_ff @(posedge clk) begin
    if (doPush) q[tail] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPop)  head <= head + PW'(1);
      if (doPush) tail <= tail + PW'(1);
      if (doPush && !doPop) count <= count + CW'(1);
      if (doPop && !doPush) count <= count - CW'(1);
      // a fresh drop wins over a clear on the same edge
      overflow <= (overflow && !ovfClr) || drop;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO (GPIO, TX FIFO, STATUS, CYCCNT) behind the Memory stage.
// Define MMIO_CYCCNT_EN to build the free-running CYCCNT counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter  int RAM_WORDS = 64,
  parameter  int TXQ_DEPTH = 4,
  localparam int AW = $clog2(RAM_WORDS),
  localparam int CW = $clog2(TXQ_DEPTH) + 1
) (
  input logic         clk,
  input logic         reset,
  dmem_mmio_if.slave  bus
);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] idx;
  logic          mmio;
  logic [3:0]    ofs;
  logic          selGpio;
  logic          selTx;
  logic          selSt;
  logic          selCyc;
  logic [31:0]   gpio;
  logic [31:0]   status;
  logic [31:0]   cycVal;
  logic [31:0]   rdMux;
  logic          full;
  logic          empty;
  logic          ovf;
  logic [CW-1:0] count;

  assign idx     = bus.a[AW+1:2];
  assign mmio    = isMmio(bus.a);
  assign ofs     = regOfs(bus.a);
  assign selGpio = mmio && ofs == OFS_GPIO;
  assign selTx   = mmio && ofs == OFS_TXDATA;
  assign selSt   = mmio && ofs == OFS_STATUS;
  assign selCyc  = mmio && ofs == OFS_CYCCNT;

  logic unusedAddr;
  assign unusedAddr = ^{bus.a[30:AW+2], bus.a[1:0]};

  always_ff @(posedge clk) begin
    if (bus.we && !mmio && !reset) mem[idx] <= bus.wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gpio <= '0;
    else if (bus.we && selGpio) gpio <= bus.wd;
  end

  tx_fifo #(
    .DEPTH (TXQ_DEPTH),
    .WIDTH (32)
  ) u_txq (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.we && selTx),
    .wdata    (bus.wd),
    .full     (full),
    .pop      (bus.tx_ready),
    .rdata    (bus.tx_data),
    .empty    (empty),
    .count    (count),
    .ovfClr   (bus.we && selSt && bus.wd[ST_OVF]),
    .overflow (ovf)
  );

`ifdef MMIO_CYCCNT_EN
  logic [31:0] cyc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else if (bus.we && selCyc) cyc <= '0;
    else cyc <= cyc + 32'd1;
  end

  assign cycVal = cyc;
`else
  assign cycVal = '0;
`endif

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF]   = ovf;
  end

  always_comb begin
    rdMux = '0;
    unique case (1'b1)
      !mmio:   rdMux = mem[idx];
      selGpio: rdMux = gpio;
      selTx:   rdMux = 32'(count);
      selSt:   rdMux = status;
      selCyc:  rdMux = cycVal;
      default: rdMux = '0;
    endcase
  end

  assign bus.rd       = rdMux;
  assign bus.gpio_out = gpio;
  assign bus.tx_valid = !empty;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, GPIO, TX FIFO, STATUS, reset, CYCCNT.
// TX data is checked against a queue filled as pushes are issued.
module tb_dmem_mmio;

  localparam int RW = 64;
  localparam int QD = 4;

  localparam logic [31:0] A_GPIO = 32'h8000_0000;
  localparam logic [31:0] A_TX   = 32'h8000_0004;
  localparam logic [31:0] A_ST   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_000C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] txq [$];

  dmem_mmio_if bus();

  dmem_mmio #(
    .RAM_WORDS (RW),
    .TXQ_DEPTH (QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sbChk(
    input string       tag,
    input logic [31:0] obs
  );
    if (txq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=<none>", tag, obs);
    end else begin
      chk(tag, obs, txq.pop_front());
    end
  endtask

  task automatic wr(
    input logic [31:0] addr,
    input logic [31:0] data
  );
    @(negedge clk);
    bus.a  = addr;
    bus.wd = data;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rdc(
    input string       tag,
    input logic [31:0] addr,
    input logic [31:0] exp
  );
    @(negedge clk);
    bus.a = addr;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  task automatic drain(
    input string tag
  );
    int budget;
    budget = 20;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    while (txq.size() > 0 && budget > 0) begin
      #1;
      if (bus.tx_valid === 1'b1) sbChk(tag, bus.tx_data);
      budget--;
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    if (txq.size() > 0) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=%0d left expected=0", tag, txq.size());
      txq.delete();
    end
  endtask

  initial begin
    logic [31:0] v1;
    bus.we       = 1'b0;
    bus.a        = '0;
    bus.wd       = '0;
    bus.tx_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_gpio", bus.gpio_out, 32'h0);
    chk("rst_txv", {31'h0, bus.tx_valid}, 32'h0);
    bus.a  = A_GPIO;
    bus.wd = 32'hFF;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    chk("rst_wr_ignored", bus.gpio_out, 32'h0);
    reset = 1'b0;

    rdc("rst_status", A_ST, 32'h2);
    rdc("rst_occ", A_TX, 32'h0);

    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rdc("ram_10", 32'h10, 32'hDEAD_BEEF);
    rdc("ram_14", 32'h14, 32'h1234_5678);
    rdc("ram_alias", 32'h10 + 4 * RW, 32'hDEAD_BEEF);

    wr(A_GPIO, 32'hA5);
    chk("gpio_out", bus.gpio_out, 32'hA5);
    rdc("gpio_rd", A_GPIO, 32'hA5);

    for (int i = 1; i <= 5; i++) begin
      wr(A_TX, 32'(i));
      if (i <= QD) txq.push_back(32'(i));
      if (i == 1) chk("txv_rise", {31'h0, bus.tx_valid}, 32'h1);
    end
    rdc("fill_occ", A_TX, 32'h4);
    rdc("fill_status", A_ST, 32'h5);
    drain("drain1");
    #1;
    chk("drain1_txv", {31'h0, bus.tx_valid}, 32'h0);
    rdc("drain1_status", A_ST, 32'h6);
    wr(A_ST, 32'h4);
    rdc("ovf_clr", A_ST, 32'h2);

    for (int i = 5; i <= 8; i++) begin
      wr(A_TX, 32'(i));
      txq.push_back(32'(i));
    end
    rdc("full_status", A_ST, 32'h1);
    @(negedge clk);
    bus.a        = A_TX;
    bus.wd       = 32'h9;
    bus.we       = 1'b1;
    bus.tx_ready = 1'b1;
    txq.push_back(32'h9);
    #1;
    sbChk("simul_head", bus.tx_data);
    @(negedge clk);
    bus.we       = 1'b0;
    bus.tx_ready = 1'b0;
    rdc("simul_occ", A_TX, 32'h4);
    rdc("simul_status", A_ST, 32'h1);
    drain("drain2");
    #1;
    chk("drain2_txv", {31'h0, bus.tx_valid}, 32'h0);

    wr(A_TX, 32'hA);
    wr(A_TX, 32'hB);
    wr(A_TX, 32'hC);
    rdc("pre_rst_occ", A_TX, 32'h3);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_txv", {31'h0, bus.tx_valid}, 32'h0);
    chk("arst_gpio", bus.gpio_out, 32'h0);
    #1;
    chk("arst_occ", bus.rd, 32'h0);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rdc("arst_status", A_ST, 32'h2);

`ifdef MMIO_CYCCNT_EN
    @(negedge clk);
    bus.a = A_CYC;
    #1;
    v1 = bus.rd;
    @(negedge clk);
    #1;
    chk("cyc_step", bus.rd, v1 + 32'd1);
    wr(A_CYC, 32'h1234);
    #1;
    chk("cyc_zero", bus.rd, 32'h0);
    @(negedge clk);
    #1;
    chk("cyc_one", bus.rd, 32'h1);
`else
    v1 = 32'h0;
    rdc("cyc_off", A_CYC, v1);
    wr(A_CYC, 32'h55);
    rdc("cyc_off_wr", A_CYC, v1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory for the pipelined ARM core: it sits directly downstream of the core's Memory stage and consumes MemWrite/ALUResult/WriteData, returning ReadData in the same cycle. Low addresses select a word-addressed data RAM. Addresses with bit 31 set select memory-mapped I/O:
- GPIO output register
- transmit FIFO drained over a valid/ready port
- status register
- optional free-running cycle counter

## Interface
Parameters:
- RAM_WORDS, 64: data RAM depth in 32-bit words (power of 2).
- TXQ_DEPTH, 4: transmit FIFO depth in entries (power of 2, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- we  input  1  write enable (core MemWrite).
- a  input  32  byte address (core ALUResult); bits [1:0] ignored.
- wd  input  32  write data (core WriteData).
- rd  output  32  read data (core ReadData), combinational.
- gpio_out  output  32  GPIO register value.
- tx_valid  output  1  FIFO non-empty.
- tx_data  output  32  FIFO head entry.
- tx_ready  input  1  consumer accepts head this cycle.

## Operation
- RAM region, a[31]=0:
  - Word index is a[log2(RAM_WORDS)+1:2]; upper address bits are aliased.
  - Writes occur at the clock edge when we=1.
- MMIO region, a[31]=1, decoded on a[3:2]:
  - 0x8000_0000 GPIO: read returns gpio_out; write loads wd.
  - 0x8000_0004 TXDATA: write pushes wd into FIFO; read returns zero-extended FIFO occupancy (0..TXQ_DEPTH).
  - 0x8000_0008 STATUS: read gives bit0 full, bit1 empty, bit2 sticky overflow, other bits 0. Writing with wd[2]=1 clears overflow; other bits are ignored.
  - 0x8000_000C CYCCNT: see Configuration.
  - a[30:4] is ignored within MMIO, so the map is aliased.
- FIFO:
  - A pop occurs on an edge where tx_valid && tx_ready.
  - A push occurs on an edge where a TXDATA write is presented and the FIFO is not full, or a pop occurs on that same edge.
  - A push when full with no pop is dropped and sets overflow.
  - Circular head/tail pointers wrap modulo TXQ_DEPTH. Occupancy is a count register of log2(TXQ_DEPTH)+1 bits.
- Priorities:
  - A simultaneous push and pop leaves occupancy unchanged.
  - Overflow clear and a new overflow on the same edge leave overflow = 1.

## Timing
- rd is combinational from a and the current state, with zero latency.
- Writes take effect at the edge when we=1; a read of the same address in the next cycle returns the new value.
- A push into an empty FIFO makes tx_valid rise the cycle after the write edge. There is no bypass.
- tx_data is stable while tx_valid=1 and no pop occurs.
- Reset (asynchronous, also mid-operation) sets:
  - gpio_out=0
  - FIFO empty (tx_valid=0, occupancy 0, pointers 0)
  - overflow=0
  - cycle counter=0
- RAM contents are not reset and are undefined until written.
- While reset is asserted, writes are ignored.

## Configuration
- MMIO_CYCCNT_EN defined:
  - A 32-bit counter increments every cycle after reset deassertion and wraps 0xFFFF_FFFF→0.
  - A read of CYCCNT returns the current value.
  - A write of any value to CYCCNT sets it to 0 on that edge; the write has priority over the increment.
- MMIO_CYCCNT_EN undefined:
  - No counter register exists.
  - CYCCNT reads return 0 and writes are ignored.

## Structure
- Package dmem_mmio_pkg holds:
  - MMIO_BASE (32'h8000_0000)
  - register offsets OFS_GPIO/OFS_TXDATA/OFS_STATUS/OFS_CYCCNT
  - STATUS bit positions
- Sub-module tx_fifo:
  - Parameterised by depth and width.
  - Ports: push/wdata/full, pop/rdata/empty, count, overflow.
- dmem_mmio contains the RAM array, the address decode, the GPIO register and the counter.

## Test plan
- RAM round trip:
  - Write 0xDEADBEEF to 0x10 and 0x12345678 to 0x14.
  - Read 0x10 → 0xDEADBEEF, 0x14 → 0x12345678.
  - Read 0x10+4*RAM_WORDS → 0xDEADBEEF (aliasing).
- GPIO:
  - Reset → gpio_out=0.
  - Write 0xA5 to 0x8000_0000 → gpio_out=0xA5 from the next cycle; readback 0xA5.
- FIFO fill/overflow, with tx_ready=0:
  - Push 1..5 with TXQ_DEPTH=4 → TXDATA read 4, STATUS 0x5 (full + overflow).
  - Set tx_ready=1 → tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS 0x6.
  - Write STATUS 0x4 → STATUS 0x2.
- Simultaneous push/pop when full, with tx_ready=1 and push 9 on the same edge:
  - Occupancy stays 4, overflow stays 0.
  - 9 is emitted last.
- Reset mid-drain:
  - Assert reset asynchronously with 3 entries queued → tx_valid=0 immediately, occupancy 0, gpio_out=0.
- Cycle counter with MMIO_CYCCNT_EN:
  - Read 0x8000_000C on successive cycles → values differ by 1.
  - Write → next-cycle read 1.
  - Without the macro, reads return 0.
